uart_rx_core: RTL and testbench

//  Receive side of the UART link; consumes the serial stream the TX side produces.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 59 +++++
 rtl/uart_rx_core.sv | 144 ++++++++++++++
 tb/tb_uart_rx_core.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and the parity helper.
// Imported by the RX core, the RX sampler and the TX serializer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  localparam int MAX_DW = 16;

  // Parity bit the line should carry: even when odd=0, odd when odd=1.
  function automatic logic par_calc(
    input logic [MAX_DW-1:0] d,
    input logic              odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-FF synchronizer, per-bit edge counter and
// three-sample mid-bit majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic rx_in,
  input  logic run,
  output logic rx_s,
  output logic bit_val,
  output logic bit_done
);

  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] S2   = EW'(PRESCALE / 2 + 1);

  logic          meta_q;
  logic          sync_q;
  logic [EW-1:0] edge_q, edge_d;
  logic [2:0]    smp_q, smp_d;

  always_comb begin
    edge_d = '0;
    smp_d  = smp_q;
    if (run) begin
      edge_d = (edge_q == LAST) ? '0 : edge_q + 1'b1;
      if (edge_q == S0) smp_d[0] = sync_q;
      if (edge_q == S1) smp_d[1] = sync_q;
      if (edge_q == S2) smp_d[2] = sync_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
      edge_q <= '0;
      smp_q  <= '0;
    end else begin
      meta_q <= rx_in;
      sync_q <= meta_q;
      edge_q <= edge_d;
      smp_q  <= smp_d;
    end
  end

  assign rx_s     = sync_q;
  assign bit_done = run && (edge_q == LAST);
  assign bit_val  = (smp_q[0] & smp_q[1]) |
                    (smp_q[0] & smp_q[2]) |
                    (smp_q[1] & smp_q[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: frame FSM, data shift register, parity/stop checks
// and registered one-cycle result pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_flag_q, par_flag_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic rx_s;
  logic bit_val;
  logic bit_done;
  logic run;

  assign run = (state_q != ST_IDLE);

  uart_rx_sampler #(
    .PRESCALE (PRESCALE)
  ) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .rx_in    (RX_IN),
    .run      (run),
    .rx_s     (rx_s),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_flag_d = par_flag_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_s == START_BIT) begin
          state_d    = ST_START;
          bit_cnt_d  = '0;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_flag_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done)
          state_d = (bit_val != START_BIT) ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          if (bit_val != par_calc(MAX_DW'(shift_q), par_typ_q)) begin
            par_flag_d = 1'b1;
            pe_d       = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
          if (bit_val != STOP_BIT) begin
            se_d = 1'b1;
          end else if (!par_flag_q) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_flag_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_flag_q <= par_flag_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames queue their expected pulses,
// a negedge monitor pops and checks kind, arrival cycle and P_DATA.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PS = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_core #(
    .DATA_WIDTH (DW),
    .PRESCALE   (PS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic take(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pulse kind=%0d cycle=%0d data=%0h",
               kind, cyc, P_DATA);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || cyc < e.lo || cyc > e.hi || P_DATA !== e.data) begin
        failures++;
        $display("FAIL pulse actual kind=%0d cyc=%0d data=%0h required kind=%0d cyc=%0d..%0d data=%0h",
                 kind, cyc, P_DATA, e.kind, e.lo, e.hi, e.data);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (data_valid) take(0);
      if (par_err) take(1);
      if (stp_err) take(2);
    end
  end

  // exp_kind: -1 none, 0 valid, 1 parity err, 2 stop err, 3 parity+stop err
  task automatic send_frame(input logic [7:0] d, input logic pe,
                            input logic pt, input logic par_bit,
                            input logic stop, input logic flip,
                            input int exp_kind, input int slack);
    int   k;
    int   nb;
    logic b;
    nb = pe ? 11 : 10;
    PAR_EN = pe;
    PAR_TYP = pt;
    @(negedge CLK);
    k = cyc;
    if (exp_kind == 0) begin
      exp_q.push_back('{0, d, k + 3 + 8 * nb, k + 3 + 8 * nb + slack});
      last_good = d;
    end
    if (exp_kind == 1 || exp_kind == 3)
      exp_q.push_back('{1, last_good, k + 3 + 8 * (nb - 1),
                        k + 3 + 8 * (nb - 1) + slack});
    if (exp_kind == 2 || exp_kind == 3)
      exp_q.push_back('{2, last_good, k + 3 + 8 * nb, k + 3 + 8 * nb + slack});
    for (int j = 0; j < nb; j++) begin
      if (j == 0) b = 1'b0;
      else if (j <= 8) b = d[j-1];
      else if (pe && j == 9) b = par_bit;
      else b = stop;
      for (int c = 0; c < PS; c++) begin
        if (!(j == 0 && c == 0)) @(negedge CLK);
        RX_IN = b ^ (flip && c == 5);
        if (j == 1 && c == 0) begin
          PAR_EN = ~pe;
          PAR_TYP = ~pt;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge CLK);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_pdata", P_DATA, 0);
    check("rst_dv", data_valid, 0);
    check("rst_pe", par_err, 0);
    check("rst_se", stp_err, 0);
    check("rst_state", dut.state_q, ST_IDLE);
    RST = 1'b1;
    idle(5);

    send_frame(8'hA5, 0, 0, 0, 1, 0, 0, 0);
    idle(10);
    drain("drain_a5");

    send_frame(8'h3C, 1, 0, 0, 1, 0, 0, 0);
    idle(10);
    drain("drain_3c_even");

    send_frame(8'h3C, 1, 1, 0, 1, 0, 1, 0);
    idle(10);
    drain("drain_3c_odd");

    send_frame(8'h81, 0, 0, 0, 0, 0, 2, 0);
    idle(20);
    drain("drain_stop");
    check("idle_after_stp", dut.state_q, ST_IDLE);

    send_frame(8'h3C, 1, 1, 0, 0, 0, 3, 0);
    idle(20);
    drain("drain_both_err");

    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    idle(20);
    check("glitch_idle", dut.state_q, ST_IDLE);
    check("glitch_quiet", exp_q.size(), 0);

    send_frame(8'h5A, 0, 0, 0, 1, 1, 0, 0);
    idle(10);
    drain("drain_flip");

    send_frame(8'h11, 0, 0, 0, 1, 0, 0, 0);
    send_frame(8'h22, 0, 0, 0, 1, 0, 0, 1);
    idle(10);
    drain("drain_b2b");

    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 24; i++) begin
      RX_IN = i[3];
      @(negedge CLK);
    end
    check("pre_rst_state", dut.state_q, ST_DATA);
    RST = 1'b0;
    RX_IN = 1'b1;
    #1;
    check("mid_rst_pdata", P_DATA, 0);
    check("mid_rst_state", dut.state_q, ST_IDLE);
    repeat (3) @(negedge CLK);
    check("mid_rst_dv", data_valid, 0);
    RST = 1'b1;
    last_good = 8'h00;
    idle(5);
    send_frame(8'h77, 0, 0, 0, 1, 0, 0, 0);
    idle(10);
    drain("drain_77");
    check("final_pdata", P_DATA, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
